data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Byte-addressed data memory acting as the responder end of the processor's load/store interface.
- Accepts one word request at a time over a valid/ready handshake and returns the response after a fixed, parameterised latency, with back-pressure.
- Replaces the zero-latency combinational data memory so the core can be exercised against realistic memory timing.

Parameters:
- WIDTH, 32, data and address width.
- DEPTH, 256, memory size in bytes; power of two.
- LATENCY, 2, cycles from request accept edge to rsp_valid high; must be >= 1.

Ports:
- clock  in  1  system clock, all state changes on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, little-endian lanes
- req_be  in  4  store byte enables, bit i gates lane i
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  WIDTH  load data; 0 for stores
- rsp_error  out  1  access faulted (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: FSM=IDLE, req_ready=1 (from the first cycle after reset), rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0.
- Reset does not clear memory contents. Memory is zero at time 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at an edge: latch write/addr/wdata/be.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge; at 0, next edge enters RESP.
- Entry edge into RESP performs the access:
  - Store: writes the enabled lanes; rsp_rdata=0.
  - Load: captures all four lanes; req_be is ignored for loads.
- Timing: rsp_valid goes high exactly LATENCY edges after the accept edge.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_error are held stable until rsp_valid&rsp_ready at an edge, which returns the FSM to IDLE.
  - req_ready=0 throughout RESP; no request is accepted in the same cycle as a response handshake.
  - Minimum occupancy is LATENCY+1 cycles per transaction.
- Addressing:
  - Lane i maps to byte (req_addr+i) mod DEPTH.
  - Address bits above log2(DEPTH) are ignored.
  - A word crossing DEPTH-1 wraps to byte 0.
- Reset mid-operation (WAIT or RESP):
  - Transaction is abandoned; FSM returns to IDLE with outputs at reset values.
  - A store whose RESP-entry edge coincides with or follows reset is not performed.
- req_* inputs are ignored outside IDLE. No internal queuing.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a request with req_addr[1:0]!=0 performs no memory write and returns rsp_rdata=0, rsp_error=1, with the same LATENCY and handshake as a normal access.
- Undefined: rsp_error is constant 0; misaligned requests access the four consecutive bytes with wrap-around as above.

Test Plan:
- Reset then idle (LATENCY=2): req_ready=1 and rsp_valid=0 from the first cycle after reset; no response without a request.
- Store then load: store 0xDEADBEEF to 0x10 with be=4'b1111, then load 0x10.
  - rsp_rdata=0xDEADBEEF.
  - rsp_valid rises exactly 2 edges after each accept.
  - Store response rdata=0.
- Partial store: store 0x0000AA00 to 0x10 with be=4'b0010, then load 0x10 -> 0xDEADAAEF.
- Back-pressure: hold rsp_ready=0 for 5 cycles during a load response with req_valid held high.
  - rsp_valid and rsp_rdata stay constant; req_ready=0; no second accept.
  - Handshake on the 6th cycle returns to IDLE.
- Wrap and misalignment:
  - Macro undefined, fresh memory: store 0x11223344 to 0x1FE, then load 0x00 -> 0x00001122; load 0xFE -> 0x11223344.
  - Macro defined: the same store returns rsp_error=1, and memory is unchanged (load 0x00 -> 0).
- Reset mid-operation: accept a store of 0xCAFEF00D to 0x20, assert reset on the next edge, then load 0x20 -> old value 0x00000000; FSM is in IDLE on the first cycle after reset.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Byte-addressed data memory responder with valid/ready request and
//            response channels and a fixed, parameterised access latency.
//            Optional macro MISALIGN_TRAP_EN faults non-word-aligned requests.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [3:0]       req_be,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_error
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;

    logic            r_write;
    logic [c_AW-1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;

    logic [31:0]     r_rdata;
    logic            r_error;

    // Power-up contents are zero; reset deliberately leaves memory untouched.
    logic [7:0]      r_mem [0:DEPTH-1] = '{default: 8'h00};

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_fault;
    logic [c_AW-1:0] w_lane_addr [4];
    logic [7:0]      w_rd_byte   [4];
    logic            w_unused_addr;

    assign w_accept      = (r_state == c_IDLE) && req_valid;
    assign w_enter_resp  = (w_next_state == c_RESP) && (r_state != c_RESP);
    assign w_unused_addr = &{1'b0, req_addr[WIDTH-1:c_AW]};

`ifdef MISALIGN_TRAP_EN
    assign w_fault = (r_addr[1:0] != 2'b00);
`else
    assign w_fault = 1'b0;
`endif

    // Lane addresses wrap naturally within the c_AW-bit byte index.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_lane_addr[i] = r_addr + c_AW'(i);
        assign w_rd_byte[i]   = r_mem[w_lane_addr[i]];
    end

    // State register and latency counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= c_CNT_INIT;
            end else if ((r_state == c_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    w_next_state = (LATENCY == 1) ? c_RESP : c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        req_ready = (r_state == c_IDLE);
        rsp_valid = (r_state == c_RESP);
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr[c_AW-1:0];
            r_wdata <= req_wdata[31:0];
            r_be    <= req_be;
        end
    end

    // Reset gating makes a store abandoned by reset leave memory intact.
    always_ff @(posedge clock) begin
        if (!reset && w_enter_resp && r_write && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_lane_addr[i]] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
            r_error <= 1'b0;
        end else if (w_enter_resp) begin
            r_error <= w_fault;
            if (r_write || w_fault) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= {w_rd_byte[3], w_rd_byte[2], w_rd_byte[1], w_rd_byte[0]};
            end
        end
    end

    assign rsp_rdata = WIDTH'(r_rdata);
    assign rsp_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed-table plus randomized bench for data_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int LAT = 2;
    localparam int DEP = 256;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [DEP];

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t vecs [9];

    always #5 clock = ~clock;

    data_mem_responder #(
        .WIDTH  (32),
        .DEPTH  (DEP),
        .LATENCY(LAT)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory: byte array, lanes at (addr+i) mod DEP.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, output logic [31:0] rd, output logic er);
        int base;
        base = int'(a % DEP);
        rd = '0;
        er = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (a[1:0] != 2'b00) begin
            er = 1'b1;
            return;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (w) begin
                if (be[i]) ref_mem[(base + i) % DEP] = d[8*i +: 8];
            end else begin
                rd[8*i +: 8] = ref_mem[(base + i) % DEP];
            end
        end
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er);
        int guard;
        int lat;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (!rsp_valid) chk({tag, " ready in wait"}, 32'(req_ready), 32'd0);
        end while (!rsp_valid && lat < 20);
        chk({tag, " latency"}, lat, LAT);
        rd = rsp_rdata;
        er = rsp_error;
        // Request inputs keep changing while valid stays high; they must be ignored.
        for (int i = 0; i < hold; i++) begin
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_write = ~w;
            @(negedge clock);
            chk({tag, " held rdata"}, rsp_rdata, rd);
            chk({tag, " held valid/ready"}, {30'd0, rsp_valid, req_ready}, 32'b10);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, " idle after rsp"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, mrd, a, d, rnd;
        logic        er, mer, w;
        logic [3:0]  be;
        int          hold;

        for (int i = 0; i < DEP; i++) ref_mem[i] = 8'h00;

        vecs[0] = '{"st_full",   1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0};
        vecs[1] = '{"ld_full",   1'b0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{"st_part",   1'b1, 32'h10,  32'h0000AA00, 4'h2, 1, 32'h0, 1'b0};
        vecs[3] = '{"ld_part",   1'b0, 32'h10,  32'h0,        4'hF, 0, 32'hDEADAAEF, 1'b0};
        vecs[4] = '{"ld_bp",     1'b0, 32'h10,  32'h0,        4'hF, 5, 32'hDEADAAEF, 1'b0};
        vecs[5] = '{"ld_be0",    1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADAAEF, 1'b0};
`ifdef MISALIGN_TRAP_EN
        vecs[6] = '{"st_wrap",   1'b1, 32'h1FE, 32'h11223344, 4'hF, 0, 32'h0, 1'b1};
        vecs[7] = '{"ld_wrap0",  1'b0, 32'h00,  32'h0,        4'hF, 0, 32'h0, 1'b0};
        vecs[8] = '{"ld_wrapFE", 1'b0, 32'hFE,  32'h0,        4'hF, 0, 32'h0, 1'b1};
`else
        vecs[6] = '{"st_wrap",   1'b1, 32'h1FE, 32'h11223344, 4'hF, 0, 32'h0, 1'b0};
        vecs[7] = '{"ld_wrap0",  1'b0, 32'h00,  32'h0,        4'hF, 0, 32'h00001122, 1'b0};
        vecs[8] = '{"ld_wrapFE", 1'b0, 32'hFE,  32'h0,        4'hF, 0, 32'h11223344, 1'b0};
`endif

        // Reset and idle
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset ready/valid", {30'd0, req_ready, rsp_valid}, 32'b10);
        chk("reset rdata", rsp_rdata, 32'h0);
        chk("reset error", 32'(rsp_error), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("idle no rsp", {30'd0, req_ready, rsp_valid}, 32'b10);
        end

        // Directed table
        for (int k = 0; k < 9; k++) begin
            model_access(vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].be, mrd, mer);
            txn(vecs[k].name, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].be, vecs[k].hold, rd, er);
            chk({vecs[k].name, " rdata"}, rd, vecs[k].exp_rd);
            chk({vecs[k].name, " error"}, 32'(er), 32'(vecs[k].exp_er));
        end

        // Store abandoned by reset on the edge after its accept
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("midreset ready/valid/err", {29'd0, req_ready, rsp_valid, rsp_error}, 32'b100);
        chk("midreset rdata", rsp_rdata, 32'h0);
        txn("ld_after_reset", 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
        chk("ld_after_reset rdata", rd, 32'h0);

        // Randomized traffic against the reference memory
        for (int n = 0; n < 80; n++) begin
            rnd = $urandom;
            a   = $urandom;
            if (rnd[0]) a[7:0] = 8'(rnd[8 +: 4]);
            else if (rnd[1]) a[7:0] = 8'hFC | 8'(rnd[12 +: 2]);
            d    = $urandom;
            be   = 4'($urandom_range(0, 15));
            w    = rnd[2];
            hold = $urandom_range(0, 3);
            model_access(w, a, d, be, mrd, mer);
            txn("rand", w, a, d, be, hold, rd, er);
            chk("rand rdata", rd, mrd);
            chk("rand error", 32'(er), 32'(mer));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
